eth_idma_reg_seq: RTL and testbench
===================================

# eth_idma_reg_seq

Register-bus sequencer that sits directly upstream of an `eth_idma_wrap` instance and drives its `reg_req_i`/`reg_rsp_o` port in place of software. It accepts one transfer descriptor at a time over a valid/ready handshake. It then programs the source, destination, length and protocol registers, polls the request-ready register, and launches the transfer with the valid/lock/response-ready write sequence. Completion or failure is reported on a done handshake. One instance drives the TX wrapper (AXI→AXIS) and another drives the RX wrapper (AXIS→AXI).

## Interface
Parameters:
- `MaxPolls`, 256: number of zero reads of 0x3c before timeout; must be ≥1.
- `PollGap`, 4: idle cycles between consecutive polls; may be 0.
- `reg_req_t`, logic: register request struct with fields `addr[31:0]`, `write`, `wdata[31:0]`, `wstrb[3:0]`, `valid`.
- `reg_rsp_t`, logic: register response struct with fields `rdata[31:0]`, `error`, `ready`.

Ports:
- `clk_i` in 1: system clock. This is the only clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `desc_valid_i` in 1: descriptor valid.
- `desc_ready_o` out 1: descriptor ready.
- `desc_src_addr_i` in 32: source address.
- `desc_dst_addr_i` in 32: destination address.
- `desc_len_i` in 32: transfer length in bytes.
- `desc_src_prot_i` in 3: source protocol (0=AXI, 5=AXIS).
- `desc_dst_prot_i` in 3: destination protocol.
- `reg_req_o` out reg_req_t: request to the wrapper.
- `reg_rsp_i` in reg_rsp_t: response from the wrapper.
- `done_valid_o` out 1: completion valid.
- `done_ready_i` in 1: completion ready.
- `done_error_o` out 1: set for bus error, timeout or zero length; valid only while `done_valid_o` is high.
- `busy_o` out 1: high in every state except IDLE.

## Operation
- **States:** IDLE, W_SRC, W_DST, W_LEN, W_SPROT, W_DPROT, R_POLL, GAP, W_VAL1, W_VAL0, W_RSPRDY, DONE.
- **IDLE:**
  - `desc_ready_o`=1.
  - On `desc_valid_i`, latch all descriptor fields and clear the poll counter and the error flag.
  - If `desc_len_i`=0, go to DONE with error=1 and issue no register access.
  - Otherwise go to W_SRC.
- **Register writes:** each W_* state writes one register with `wstrb`=4'hF; protocol values are zero-extended to 32 bits.
  - W_SRC → 0x10 = src_addr.
  - W_DST → 0x14 = dst_addr.
  - W_LEN → 0x18 = len.
  - W_SPROT → 0x1c = src_prot.
  - W_DPROT → 0x20 = dst_prot.
- **R_POLL:**
  - Read 0x3c with `write`=0 and `wstrb`=0; the poll counter increments on each completed read.
  - rdata≠0 → go to W_VAL1.
  - rdata=0 with counter=MaxPolls → go to DONE with error=1.
  - rdata=0 otherwise → go to GAP, or straight back to R_POLL if PollGap=0.
- **GAP:** count PollGap cycles with `reg_req_o.valid`=0, then return to R_POLL.
- **Launch sequence:**
  - W_VAL1 writes 0x38=1.
  - W_VAL0 writes 0x38=0.
  - W_RSPRDY writes 0x40=1, then goes to DONE with error=0.
- **Bus error:** a completed access with `error`=1 in any W_*/R_POLL state aborts the sequence. The remaining accesses are skipped and the block goes to DONE with error=1.
- **DONE:** `done_valid_o`=1 and `done_error_o` is stable. On `done_ready_i`, return to IDLE.
- **Access completion:** an access completes on a cycle where `reg_req_o.valid && reg_rsp_i.ready`. The `rdata` and `error` values are sampled on that same cycle.

## Timing
- **Reset values:**
  - `desc_ready_o`=1 and `busy_o`=0.
  - `done_valid_o`=0 and `done_error_o`=0.
  - `reg_req_o` is all zero.
  - State is IDLE and all counters are 0.
- **Registered outputs:** all `reg_req_o` fields come from flops, with no combinational path from `reg_rsp_i` to `reg_req_o`.
- **Request stability:** while `valid`=1 and `ready`=0, `addr`, `write`, `wdata` and `wstrb` are held stable.
- **Back-to-back accesses:** after a completing cycle, the next access is presented on the following cycle. `valid` may stay high across accesses, so with an always-ready slave there is one access per cycle.
- **First access:** the descriptor is accepted in cycle 0, and the first request (W_SRC) is valid in cycle 1.
- **Completion signalling:** `done_valid_o` rises the cycle after the final access completes. It rises the cycle after acceptance for a zero-length descriptor.
- **Return to IDLE:** `desc_ready_o` returns to 1 the cycle after the done handshake.
- **Descriptor isolation:** a descriptor presented while busy is not accepted, and the latched fields are unaffected.
- **Reset mid-sequence:** asserting reset mid-sequence drops any in-flight access immediately. All outputs go to their reset values and no done is reported.

## Test plan
- **Happy path:**
  - Stimulus: always-ready slave; descriptor {src 0, dst 0, len 0x40, sprot 0, dprot 5}; the first poll returns 1.
  - Required response: accesses in cycles 1–9 are W10=0, W14=0, W18=0x40, W1c=0, W20=5, R3c, W38=1, W38=0, W40=1. `done_valid_o`=1 in cycle 10 with error=0.
- **Back-pressure:**
  - Stimulus: slave asserts `ready` only every third cycle.
  - Required response: same access order as the happy path, with fields stable while stalled and done error=0.
- **Polling:**
  - Stimulus: PollGap=4; 0x3c returns 0, 0, 1.
  - Required response: exactly 3 reads, each separated by 4 idle cycles with `valid`=0, followed by the launch writes.
- **Timeout:**
  - Stimulus: MaxPolls=3; 0x3c always returns 0.
  - Required response: exactly 3 reads, no write to 0x38, done error=1.
- **Error and zero length:**
  - Stimulus A: `error`=1 on the 0x18 write. Required response: no further accesses, done error=1.
  - Stimulus B: a len=0 descriptor. Required response: zero accesses and `done_valid_o` in cycle 1 with error=1.
- **Reset and busy behaviour:**
  - Stimulus: assert `rst_ni` low during W_DPROT, then release it.
  - Required response: outputs go to their reset values and the block accepts a new descriptor.
  - Stimulus: hold `done_ready_i`=0 for 5 cycles while presenting a new descriptor.
  - Required response: `done_valid_o` stays high and the new descriptor is not accepted.

Source files
------------

// File: rtl/eth_idma_reg_seq.sv
// Register-bus sequencer for eth_idma_wrap: programs one descriptor, polls for
// request-ready, launches the transfer and reports completion on a done handshake.

package eth_idma_reg_seq_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;
endpackage

module eth_idma_reg_seq #(
    parameter int unsigned MaxPolls  = 256,
    parameter int unsigned PollGap   = 4,
    parameter type         reg_req_t = eth_idma_reg_seq_pkg::reg_req_t,
    parameter type         reg_rsp_t = eth_idma_reg_seq_pkg::reg_rsp_t
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        desc_valid_i,
    output logic        desc_ready_o,
    input  logic [31:0] desc_src_addr_i,
    input  logic [31:0] desc_dst_addr_i,
    input  logic [31:0] desc_len_i,
    input  logic [2:0]  desc_src_prot_i,
    input  logic [2:0]  desc_dst_prot_i,
    output reg_req_t    reg_req_o,
    input  reg_rsp_t    reg_rsp_i,
    output logic        done_valid_o,
    input  logic        done_ready_i,
    output logic        done_error_o,
    output logic        busy_o
);

    localparam int PollCntW = $clog2(MaxPolls + 1);
    localparam int GapCntW  = (PollGap > 1) ? $clog2(PollGap) : 1;
    localparam int unsigned GapLast = (PollGap > 0) ? PollGap - 1 : 0;

    typedef enum logic [3:0] {
        IDLE, W_SRC, W_DST, W_LEN, W_SPROT, W_DPROT,
        R_POLL, GAP, W_VAL1, W_VAL0, W_RSPRDY, DONE
    } state_e;

    state_e                state_q, state_d;
    logic                  err_q, err_d;
    logic [PollCntW-1:0]   poll_cnt_q, poll_cnt_d;
    logic [GapCntW-1:0]    gap_cnt_q, gap_cnt_d;
    reg_req_t              req_q, req_d;

    logic [31:0] src_q, dst_q, len_q;
    logic [2:0]  sprot_q, dprot_q;

    logic accept;
    logic acc_done;

    assign accept   = (state_q == IDLE) && desc_valid_i;
    assign acc_done = req_q.valid && reg_rsp_i.ready;

    function automatic reg_req_t wr_req(input logic [31:0] a, input logic [31:0] d);
        reg_req_t r;
        r       = '0;
        r.addr  = a;
        r.write = 1'b1;
        r.wdata = d;
        r.wstrb = 4'hF;
        r.valid = 1'b1;
        return r;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            err_q      <= 1'b0;
            poll_cnt_q <= '0;
            gap_cnt_q  <= '0;
            req_q      <= '0;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            poll_cnt_q <= poll_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            req_q      <= req_d;
        end
    end

    // Descriptor fields are pure data; they only matter once a descriptor is accepted.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            src_q   <= desc_src_addr_i;
            dst_q   <= desc_dst_addr_i;
            len_q   <= desc_len_i;
            sprot_q <= desc_src_prot_i;
            dprot_q <= desc_dst_prot_i;
        end
    end

    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        poll_cnt_d = poll_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        case (state_q)
            IDLE: begin
                if (desc_valid_i) begin
                    poll_cnt_d = '0;
                    err_d      = 1'b0;
                    if (desc_len_i == 32'd0) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = W_SRC;
                    end
                end
            end
            W_SRC, W_DST, W_LEN, W_SPROT, W_DPROT, W_VAL1, W_VAL0, W_RSPRDY: begin
                if (acc_done) begin
                    if (reg_rsp_i.error) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        case (state_q)
                            W_SRC:   state_d = W_DST;
                            W_DST:   state_d = W_LEN;
                            W_LEN:   state_d = W_SPROT;
                            W_SPROT: state_d = W_DPROT;
                            W_DPROT: state_d = R_POLL;
                            W_VAL1:  state_d = W_VAL0;
                            W_VAL0:  state_d = W_RSPRDY;
                            default: state_d = DONE;
                        endcase
                    end
                end
            end
            R_POLL: begin
                if (acc_done) begin
                    poll_cnt_d = poll_cnt_q + PollCntW'(1);
                    if (reg_rsp_i.error) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else if (reg_rsp_i.rdata != 32'd0) begin
                        state_d = W_VAL1;
                    end else if (poll_cnt_q == PollCntW'(MaxPolls - 1)) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else if (PollGap == 0) begin
                        state_d = R_POLL;
                    end else begin
                        state_d   = GAP;
                        gap_cnt_d = '0;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == GapCntW'(GapLast)) begin
                    state_d = R_POLL;
                end else begin
                    gap_cnt_d = gap_cnt_q + GapCntW'(1);
                end
            end
            DONE: begin
                if (done_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The request for the upcoming state is built here and registered, so the
    // bus never sees a combinational path from the response.
    always_comb begin
        req_d = '0;
        case (state_d)
            W_SRC:    req_d = wr_req(32'h10, accept ? desc_src_addr_i : src_q);
            W_DST:    req_d = wr_req(32'h14, dst_q);
            W_LEN:    req_d = wr_req(32'h18, len_q);
            W_SPROT:  req_d = wr_req(32'h1c, {29'd0, sprot_q});
            W_DPROT:  req_d = wr_req(32'h20, {29'd0, dprot_q});
            R_POLL: begin
                req_d.addr  = 32'h3c;
                req_d.valid = 1'b1;
            end
            W_VAL1:   req_d = wr_req(32'h38, 32'd1);
            W_VAL0:   req_d = wr_req(32'h38, 32'd0);
            W_RSPRDY: req_d = wr_req(32'h40, 32'd1);
            default:  req_d = '0;
        endcase
    end

    assign reg_req_o    = req_q;
    assign desc_ready_o = (state_q == IDLE);
    assign busy_o       = (state_q != IDLE);
    assign done_valid_o = (state_q == DONE);
    assign done_error_o = err_q;

endmodule

// File: tb/tb_eth_idma_reg_seq.sv
// Directed bench for eth_idma_reg_seq: scenario table plus hand-written
// sequences for done hold-off and reset in the middle of a sequence.

module tb_eth_idma_reg_seq;
    import eth_idma_reg_seq_pkg::*;

    localparam int unsigned MAXP = 3;
    localparam int unsigned GAPC = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        desc_valid = 1'b0;
    logic        desc_ready;
    logic [31:0] desc_src = '0, desc_dst = '0, desc_len = '0;
    logic [2:0]  desc_sp = '0, desc_dp = '0;
    reg_req_t    req;
    reg_rsp_t    rsp = '0;
    logic        done_valid;
    logic        done_ready = 1'b0;
    logic        done_error;
    logic        busy;

    always #5 clk = ~clk;

    eth_idma_reg_seq #(
        .MaxPolls (MAXP),
        .PollGap  (GAPC),
        .reg_req_t(reg_req_t),
        .reg_rsp_t(reg_rsp_t)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .desc_valid_i   (desc_valid),
        .desc_ready_o   (desc_ready),
        .desc_src_addr_i(desc_src),
        .desc_dst_addr_i(desc_dst),
        .desc_len_i     (desc_len),
        .desc_src_prot_i(desc_sp),
        .desc_dst_prot_i(desc_dp),
        .reg_req_o      (req),
        .reg_rsp_i      (rsp),
        .done_valid_o   (done_valid),
        .done_ready_i   (done_ready),
        .done_error_o   (done_error),
        .busy_o         (busy)
    );

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } acc_t;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          cyc;
    } log_t;

    typedef struct {
        string       name;
        logic [31:0] src, dst, len;
        logic [2:0]  sp, dp;
        int          rp;       // slave ready once every rp cycles
        logic [31:0] erra;     // address answered with error
        int          zeros;    // polls answered with 0 before a 1
        int          exp_n;
        logic        exp_err;
        int          exp_done; // -1: cycle not checked
    } scen_t;

    int   nerr = 0, nchk = 0;
    int   cnt = 0;
    int   ready_period = 1;
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    int   zeros = 0;
    int   poll_idx = 0;
    int   stab_err = 0;
    logic prev_stall = 1'b0;
    logic [68:0] prev_fields = '0;
    log_t mlog[$];
    acc_t ideal[$];
    scen_t tv[6];

    always @(posedge clk) cnt <= cnt + 1;

    // Slave: response for the current cycle, settled just after the edge.
    always @(posedge clk) begin
        #1;
        rsp.ready = (ready_period <= 1) || (cnt % ready_period == 0);
        rsp.rdata = (req.valid && !req.write && req.addr == 32'h3c && poll_idx >= zeros) ? 32'd1 : 32'd0;
        rsp.error = req.valid && (req.addr == err_addr);
    end

    always @(negedge clk) begin
        if (req.valid && rsp.ready) begin
            mlog.push_back('{req.write, req.addr, req.wdata, req.wstrb, cnt});
            if (!req.write && req.addr == 32'h3c) poll_idx++;
        end
        if (prev_stall && rst_n) begin
            if (!req.valid || {req.addr, req.write, req.wdata, req.wstrb} != prev_fields) stab_err++;
        end
        prev_stall  = req.valid && !rsp.ready && rst_n;
        prev_fields = {req.addr, req.write, req.wdata, req.wstrb};
    end

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic build_ideal(input scen_t s);
        int nreads;
        ideal.delete();
        ideal.push_back('{1'b1, 32'h10, s.src, 4'hF});
        ideal.push_back('{1'b1, 32'h14, s.dst, 4'hF});
        ideal.push_back('{1'b1, 32'h18, s.len, 4'hF});
        ideal.push_back('{1'b1, 32'h1c, {29'd0, s.sp}, 4'hF});
        ideal.push_back('{1'b1, 32'h20, {29'd0, s.dp}, 4'hF});
        nreads = (s.zeros + 1 < int'(MAXP)) ? s.zeros + 1 : int'(MAXP);
        for (int i = 0; i < nreads; i++) ideal.push_back('{1'b0, 32'h3c, 32'd0, 4'h0});
        if (s.zeros < int'(MAXP)) begin
            ideal.push_back('{1'b1, 32'h38, 32'd1, 4'hF});
            ideal.push_back('{1'b1, 32'h38, 32'd0, 4'hF});
            ideal.push_back('{1'b1, 32'h40, 32'd1, 4'hF});
        end
    endtask

    task automatic finish_done(input string name);
        @(posedge clk); #1;
        done_ready = 1'b1;
        @(posedge clk); #1;
        done_ready = 1'b0;
        check({name, " ready after done"}, desc_ready, 1'b1);
        check({name, " done dropped"}, done_valid, 1'b0);
    endtask

    task automatic run_vec(input scen_t s, input bit hold);
        int c0, done_c, n;
        @(posedge clk); #1;
        ready_period = s.rp; err_addr = s.erra; zeros = s.zeros;
        mlog.delete(); poll_idx = 0; stab_err = 0;
        check({s.name, " desc_ready idle"}, desc_ready, 1'b1);
        desc_src = s.src; desc_dst = s.dst; desc_len = s.len;
        desc_sp = s.sp; desc_dp = s.dp; desc_valid = 1'b1;
        c0 = cnt;
        @(posedge clk); #1;
        desc_valid = 1'b0;
        done_c = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (done_valid) begin
                done_c = cnt - c0;
                break;
            end
        end
        check({s.name, " done seen"}, done_c >= 0, 1'b1);
        if (s.exp_done >= 0) check({s.name, " done cycle"}, done_c, s.exp_done);
        check({s.name, " done_error"}, done_error, s.exp_err);
        check({s.name, " busy in done"}, busy, 1'b1);
        check({s.name, " access count"}, mlog.size(), s.exp_n);
        check({s.name, " stable while stalled"}, stab_err, 0);
        build_ideal(s);
        n = (mlog.size() < s.exp_n) ? mlog.size() : s.exp_n;
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s access %0d", s.name, i),
                  {mlog[i].write, mlog[i].addr, mlog[i].write ? mlog[i].wdata : 32'd0, mlog[i].wstrb},
                  {ideal[i].write, ideal[i].addr, ideal[i].write ? ideal[i].wdata : 32'd0, ideal[i].wstrb});
            if (s.rp == 1 && i < 5) check($sformatf("%s cycle %0d", s.name, i), mlog[i].cyc - c0, i + 1);
            if (s.rp == 1 && i > 5 && !mlog[i].write && !mlog[i-1].write)
                check($sformatf("%s poll spacing %0d", s.name, i), mlog[i].cyc - mlog[i-1].cyc, GAPC + 1);
        end
        if (hold) begin
            // A new descriptor waits while done is not taken.
            for (int k = 0; k < 5; k++) begin
                @(posedge clk); #1;
                desc_valid = 1'b1; desc_len = 32'h40;
                @(negedge clk);
                check($sformatf("hold done_valid %0d", k), done_valid, 1'b1);
                check($sformatf("hold desc_ready %0d", k), desc_ready, 1'b0);
                check($sformatf("hold done_error %0d", k), done_error, s.exp_err);
            end
            check("hold no access", mlog.size(), s.exp_n);
            @(posedge clk); #1;
            desc_valid = 1'b0;
        end
        finish_done(s.name);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int found, spurious;
        tv[0] = '{"happy",   32'h0,         32'h0,         32'h40,  3'd0, 3'd5, 1, 32'hFFFF_FFFF, 0,  9,  1'b0, 10};
        tv[1] = '{"backpr",  32'h1000_0000, 32'h2000_0040, 32'h100, 3'd0, 3'd5, 3, 32'hFFFF_FFFF, 0,  9,  1'b0, -1};
        tv[2] = '{"polling", 32'h0000_A000, 32'h0000_B000, 32'h80,  3'd5, 3'd0, 1, 32'hFFFF_FFFF, 2,  11, 1'b0, 20};
        tv[3] = '{"timeout", 32'h0000_0100, 32'h0000_0200, 32'h20,  3'd0, 3'd5, 1, 32'hFFFF_FFFF, 99, 8,  1'b1, 17};
        tv[4] = '{"buserr",  32'h0000_0300, 32'h0000_0400, 32'h10,  3'd5, 3'd0, 1, 32'h18,        0,  3,  1'b1, 4};
        tv[5] = '{"zerolen", 32'h0000_0500, 32'h0000_0600, 32'h0,   3'd0, 3'd5, 1, 32'hFFFF_FFFF, 0,  0,  1'b1, 1};

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #3;
        check("rst desc_ready", desc_ready, 1'b1);
        check("rst busy", busy, 1'b0);
        check("rst done_valid", done_valid, 1'b0);
        check("rst done_error", done_error, 1'b0);
        check("rst req", req, 96'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-rst req", req, 96'd0);

        for (int i = 0; i < 6; i++) run_vec(tv[i], 1'b0);

        run_vec(tv[5], 1'b1);

        // Reset while the DPROT write is on the bus.
        @(posedge clk); #1;
        ready_period = 1; err_addr = 32'hFFFF_FFFF; zeros = 0; poll_idx = 0;
        desc_src = 32'h77; desc_dst = 32'h88; desc_len = 32'h40; desc_sp = 3'd0; desc_dp = 3'd5;
        desc_valid = 1'b1;
        @(posedge clk); #1;
        desc_valid = 1'b0;
        found = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req.valid && req.addr == 32'h20) begin
                found = 1;
                break;
            end
        end
        check("midrst reached dprot", found, 1);
        rst_n = 1'b0;
        #1;
        check("midrst req", req, 96'd0);
        check("midrst busy", busy, 1'b0);
        check("midrst desc_ready", desc_ready, 1'b1);
        check("midrst done_valid", done_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done_valid || req.valid) spurious++;
        end
        check("midrst no done or access", spurious, 0);
        run_vec(tv[0], 1'b0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
